// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: loads weights and biases, then evaluates OUT_N neurons over IN_N inputs.
// Build option: define NN_LAYER_RELU_EN for a ReLU activation; otherwise the activation is identity.
module nn_layer_engine #(
  parameter int IN_N  = 2,
  parameter int OUT_N = 2,
  parameter int DW    = 8,
  parameter int FRAC  = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             fill,
  input  logic                                             req,
  input  logic                                             wt_valid,
  input  logic [DW-1:0]                                    wt_data,
  output logic                                             ack_fill,
  output logic                                             ack_network,
  output logic                                             in_trig_r,
  output logic [((IN_N > 1) ? $clog2(IN_N) : 1)-1:0]       in_abus_r,
  input  logic [DW-1:0]                                    in_dbus_r,
  output logic                                             out_trig_w,
  output logic [((OUT_N > 1) ? $clog2(OUT_N) : 1)-1:0]     out_abus_w,
  output logic [DW-1:0]                                    out_dbus_w
);

  localparam int IAW = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int OAW = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int NWI = IN_N * OUT_N;
  localparam int NW  = NWI + OUT_N;
  localparam int MW  = $clog2(NW);
  localparam int FW  = $clog2(NW + 1);
  localparam int CW  = $clog2(IN_N + 1);
  localparam int AW  = 2 * DW + $clog2(IN_N + 1) + 1;
  localparam logic signed [AW-1:0] SMAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {IDLE, FILL, FDONE, MAC, WRITE, DONE} state_t;

  state_t                 state;
  logic                   loaded;
  logic [FW-1:0]          fcnt;
  logic [CW-1:0]          cnt;
  logic [OAW-1:0]         nrn;
  logic                   rd_v;
  logic [IAW-1:0]         rd_idx;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_next;
  logic signed [AW-1:0]   bias_init;
  logic signed [AW-1:0]   shifted;
  logic signed [2*DW-1:0] prod;
  logic [DW-1:0]          wb;
  logic [DW-1:0]          sat_r;
  logic [DW-1:0]          act_r;
  logic [OAW-1:0]         b_sel;
  logic [MW-1:0]          w_addr;
  logic [MW-1:0]          b_addr;
  logic [DW-1:0]          wmem [NW];

  // Weight storage deliberately has no reset; validity is tracked by loaded.
  always_ff @(posedge clk) begin
    if (state == FILL && fill && wt_valid)
      wmem[MW'(fcnt)] <= wt_data;
  end

  always_comb begin
    b_sel     = (state == WRITE) ? nrn + OAW'(1) : '0;
    b_addr    = MW'(NWI + int'(b_sel));
    w_addr    = MW'(int'(nrn) * IN_N + int'(rd_idx));
    wb        = wmem[b_addr];
    bias_init = $signed({{(AW-DW){wb[DW-1]}}, wb}) <<< FRAC;
    prod      = $signed(wmem[w_addr]) * $signed(in_dbus_r);
    acc_next  = acc + (rd_v ? {{(AW-2*DW){prod[2*DW-1]}}, prod} : '0);
    shifted   = acc_next >>> FRAC;
    if (shifted > SMAX)
      sat_r = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SMIN)
      sat_r = {1'b1, {(DW-1){1'b0}}};
    else
      sat_r = shifted[DW-1:0];
`ifdef NN_LAYER_RELU_EN
    act_r = sat_r[DW-1] ? '0 : sat_r;
`else
    act_r = sat_r;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      loaded      <= 1'b0;
      fcnt        <= '0;
      cnt         <= '0;
      nrn         <= '0;
      rd_v        <= 1'b0;
      rd_idx      <= '0;
      acc         <= '0;
      ack_fill    <= 1'b0;
      ack_network <= 1'b0;
      in_trig_r   <= 1'b0;
      in_abus_r   <= '0;
      out_trig_w  <= 1'b0;
      out_abus_w  <= '0;
      out_dbus_w  <= '0;
    end else begin
      // Read data arrives one cycle after the strobe, so the MAC stage lags the address stage.
      rd_v       <= in_trig_r;
      rd_idx     <= in_abus_r;
      out_trig_w <= 1'b0;
      case (state)
        IDLE: begin
          if (fill) begin
            state  <= FILL;
            loaded <= 1'b0;
            fcnt   <= '0;
          end else if (req && loaded) begin
            state     <= MAC;
            nrn       <= '0;
            cnt       <= '0;
            acc       <= bias_init;
            in_trig_r <= 1'b1;
            in_abus_r <= '0;
          end
        end
        FILL: begin
          if (!fill) begin
            state  <= IDLE;
            loaded <= 1'b0;
          end else if (wt_valid) begin
            fcnt <= fcnt + FW'(1);
            if (int'(fcnt) == NW - 1) begin
              state    <= FDONE;
              loaded   <= 1'b1;
              ack_fill <= 1'b1;
            end
          end
        end
        FDONE: begin
          if (!fill) begin
            state    <= IDLE;
            ack_fill <= 1'b0;
          end
        end
        MAC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (int'(cnt) + 1 < IN_N) begin
            in_trig_r <= 1'b1;
            in_abus_r <= IAW'(int'(cnt) + 1);
          end else begin
            in_trig_r <= 1'b0;
          end
          // The final product is folded in combinationally so the write strobe lines up with WRITE.
          if (int'(cnt) == IN_N) begin
            state      <= WRITE;
            out_trig_w <= 1'b1;
            out_abus_w <= nrn;
            out_dbus_w <= act_r;
          end
        end
        WRITE: begin
          if (int'(nrn) == OUT_N - 1) begin
            state <= DONE;
          end else begin
            state     <= MAC;
            nrn       <= nrn + OAW'(1);
            cnt       <= '0;
            acc       <= bias_init;
            in_trig_r <= 1'b1;
            in_abus_r <= '0;
          end
        end
        DONE: begin
          if (ack_network && !req) begin
            state       <= IDLE;
            ack_network <= 1'b0;
          end else begin
            ack_network <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Randomised bench for nn_layer_engine: a cycle-scheduled behavioural model predicts every read and write.
module tb_nn_layer_engine;

  localparam int IN_N  = 2;
  localparam int OUT_N = 2;
  localparam int DW    = 8;
  localparam int FRAC  = 4;
  localparam int NW    = IN_N * OUT_N + OUT_N;
  localparam int LAT   = IN_N + 2;
`ifdef NN_LAYER_RELU_EN
  localparam int LIT_NEG    = 0;
  localparam int LIT_SATNEG = 0;
`else
  localparam int LIT_NEG    = -32;
  localparam int LIT_SATNEG = -128;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fill = 1'b0;
  logic          req = 1'b0;
  logic          wt_valid = 1'b0;
  logic [DW-1:0] wt_data = '0;
  logic          ack_fill;
  logic          ack_network;
  logic          in_trig_r;
  logic [0:0]    in_abus_r;
  logic [DW-1:0] in_dbus_r = '0;
  logic          out_trig_w;
  logic [0:0]    out_abus_w;
  logic [DW-1:0] out_dbus_w;

  nn_layer_engine #(.IN_N(IN_N), .OUT_N(OUT_N), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .fill(fill), .req(req), .wt_valid(wt_valid), .wt_data(wt_data),
    .ack_fill(ack_fill), .ack_network(ack_network),
    .in_trig_r(in_trig_r), .in_abus_r(in_abus_r), .in_dbus_r(in_dbus_r),
    .out_trig_w(out_trig_w), .out_abus_w(out_abus_w), .out_dbus_w(out_dbus_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  int  m_w [OUT_N][IN_N];
  int  m_b [OUT_N];
  bit  m_loaded = 0;
  int  fw [NW];
  int  in_mem [IN_N];
  int  exp_rd [int];
  int  exp_wa [int];
  int  exp_wd [int];
  int  last_wr [OUT_N];

  // Synchronous input memory: data for a strobe appears one cycle later, junk otherwise.
  logic mt;
  int   ma;
  always @(posedge clk) begin
    mt = in_trig_r;
    ma = int'(in_abus_r);
    #1 in_dbus_r = mt ? DW'(in_mem[ma]) : DW'($urandom);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int ref_out(int j);
    int a = m_b[j] * (1 << FRAC);
    for (int i = 0; i < IN_N; i++) a += m_w[j][i] * in_mem[i];
    a = a >>> FRAC;
    if (a > (1 << (DW - 1)) - 1) a = (1 << (DW - 1)) - 1;
    else if (a < -(1 << (DW - 1))) a = -(1 << (DW - 1));
`ifdef NN_LAYER_RELU_EN
    if (a < 0) a = 0;
`endif
    return a;
  endfunction

  always @(negedge clk) begin
    if (exp_rd.exists(cyc)) begin
      chk("in_trig_r", int'(in_trig_r), 1);
      chk("in_abus_r", int'(in_abus_r), exp_rd[cyc]);
    end else begin
      chk("in_trig_r quiet", int'(in_trig_r), 0);
    end
    if (exp_wa.exists(cyc)) begin
      chk("out_trig_w", int'(out_trig_w), 1);
      chk("out_abus_w", int'(out_abus_w), exp_wa[cyc]);
      chk("out_dbus_w", int'($signed(out_dbus_w)), exp_wd[cyc]);
    end else begin
      chk("out_trig_w quiet", int'(out_trig_w), 0);
    end
    if (out_trig_w) last_wr[int'(out_abus_w)] = int'($signed(out_dbus_w));
  end

  task automatic schedule_eval(input int e);
    for (int j = 0; j < OUT_N; j++) begin
      for (int i = 0; i < IN_N; i++) exp_rd[e + j * LAT + i] = i;
      exp_wa[e + j * LAT + IN_N + 1] = j;
      exp_wd[e + j * LAT + IN_N + 1] = ref_out(j);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " ack_fill"}, int'(ack_fill), 0);
    chk({tag, " ack_network"}, int'(ack_network), 0);
    chk({tag, " in_trig_r"}, int'(in_trig_r), 0);
    chk({tag, " in_abus_r"}, int'(in_abus_r), 0);
    chk({tag, " out_trig_w"}, int'(out_trig_w), 0);
    chk({tag, " out_abus_w"}, int'(out_abus_w), 0);
    chk({tag, " out_dbus_w"}, int'(out_dbus_w), 0);
  endtask

  task automatic clear_last();
    for (int j = 0; j < OUT_N; j++) last_wr[j] = 999;
  endtask

  task automatic do_fill(input int nwords, input bit with_req);
    @(negedge clk);
    fill = 1; req = with_req; wt_valid = 1; wt_data = DW'($urandom);
    m_loaded = 0;
    @(negedge clk);
    req = 0;
    for (int k = 0; k < nwords; k++) begin
      chk("ack_fill while loading", int'(ack_fill), 0);
      while ($urandom_range(0, 3) == 0) begin
        wt_valid = 0; wt_data = DW'($urandom);
        @(negedge clk);
      end
      wt_valid = 1; wt_data = DW'(fw[k]);
      if (k < IN_N * OUT_N) m_w[k / IN_N][k % IN_N] = fw[k];
      else m_b[k - IN_N * OUT_N] = fw[k];
      @(negedge clk);
    end
    wt_valid = 0; wt_data = '0;
    if (nwords == NW) begin
      chk("ack_fill complete", int'(ack_fill), 1);
      m_loaded = 1;
    end else begin
      chk("ack_fill aborted", int'(ack_fill), 0);
    end
    fill = 0;
    @(negedge clk);
    chk("ack_fill release", int'(ack_fill), 0);
  endtask

  task automatic run_req(input bit drop_early);
    int e, ack_at;
    bit seen;
    @(negedge clk);
    e = cyc + 1;
    if (m_loaded) schedule_eval(e);
    req = 1;
    if (drop_early) begin
      @(negedge clk);
      req = 0;
    end
    seen = 0; ack_at = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ack_network) begin seen = 1; ack_at = cyc; end
    end
    if (m_loaded) chk("ack_network rise cycle", ack_at, e + OUT_N * LAT + 1);
    else chk("ack_network without weights", int'(seen), 0);
    req = 0;
    @(negedge clk);
    chk("ack_network release", int'(ack_network), 0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    clear_last();
    for (int i = 0; i < IN_N; i++) in_mem[i] = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1;

    // No weights loaded, then a load dropped after 3 of 6 words.
    run_req(0);
    for (int k = 0; k < NW; k++) fw[k] = int'($urandom_range(0, 255)) - 128;
    do_fill(3, 0);
    run_req(0);

    // fill wins over a simultaneous req; two identical back-to-back evaluations.
    for (int k = 0; k < NW; k++) fw[k] = (k < IN_N * OUT_N) ? -16 : 0;
    in_mem[0] = 16; in_mem[1] = 16;
    do_fill(NW, 1);
    clear_last();
    run_req(0);
    chk("lit neg n0", last_wr[0], LIT_NEG);
    chk("lit neg n1", last_wr[1], LIT_NEG);
    clear_last();
    run_req(0);
    chk("lit neg again n0", last_wr[0], LIT_NEG);
    chk("lit neg again n1", last_wr[1], LIT_NEG);

    // Positive saturation, req dropped during MAC.
    for (int k = 0; k < NW; k++) fw[k] = 127;
    in_mem[0] = 127; in_mem[1] = 127;
    do_fill(NW, 0);
    clear_last();
    run_req(1);
    chk("lit sat pos n0", last_wr[0], 127);
    chk("lit sat pos n1", last_wr[1], 127);

    // Negative saturation.
    for (int k = 0; k < NW; k++) fw[k] = -128;
    do_fill(NW, 0);
    clear_last();
    run_req(0);
    chk("lit sat neg n0", last_wr[0], LIT_SATNEG);
    chk("lit sat neg n1", last_wr[1], LIT_SATNEG);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < NW; k++) fw[k] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < IN_N; i++) in_mem[i] = int'($urandom_range(0, 255)) - 128;
      do_fill(NW, r == 3);
      run_req(bit'($urandom_range(0, 1)));
      for (int i = 0; i < IN_N; i++) in_mem[i] = int'($urandom_range(0, 255)) - 128;
      run_req(0);
    end

    // Asynchronous reset in the middle of MAC.
    for (int k = 0; k < NW; k++) fw[k] = int'($urandom_range(0, 255)) - 128;
    do_fill(NW, 0);
    @(negedge clk);
    e = cyc + 1;
    schedule_eval(e);
    req = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    m_loaded = 0;
    #1 chk_outputs_zero("async reset");
    req = 0;
    @(negedge clk);
    #2 rst = 1;
    run_req(0);
    do_fill(NW, 0);
    run_req(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nn_layer_engine.md
NN_LAYER_ENGINE -- requirements
Module: nn_layer_engine

Interface
REQ-001 SHALL have parameter IN_N, default 2: number of layer inputs, at least 1.
REQ-002 SHALL have parameter OUT_N, default 2: number of neurons, at least 1.
REQ-003 SHALL have parameter DW, default 8: signed data/weight width.
REQ-004 SHALL have parameter FRAC, default 4: fractional bits, so 16 represents 1.0.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port fill, input, 1: request to load weights.
REQ-008 SHALL have port req, input, 1: request to evaluate the layer.
REQ-009 SHALL have port wt_valid, input, 1: weight word present during fill.
REQ-010 SHALL have port wt_data, input, DW: signed weight or bias word.
REQ-011 SHALL have port ack_fill, output, 1: weight load complete.
REQ-012 SHALL have port ack_network, output, 1: evaluation complete.
REQ-013 SHALL have port in_trig_r, output, 1: input-memory read strobe.
REQ-014 SHALL have port in_abus_r, output, clog2(IN_N) (minimum 1): input read address.
REQ-015 SHALL have port in_dbus_r, input, DW: signed input read data, valid one cycle after in_trig_r.
REQ-016 SHALL have port out_trig_w, output, 1: output-memory write strobe.
REQ-017 SHALL have port out_abus_w, output, clog2(OUT_N) (minimum 1): output write address.
REQ-018 SHALL have port out_dbus_w, output, DW: signed output write data.

Function
REQ-019 SHALL implement the states IDLE, FILL, FDONE, MAC, WRITE and DONE.
REQ-020 IDLE with fill=1 SHALL go to FILL; fill takes priority over a simultaneous req.
REQ-021 FILL SHALL store one wt_data per cycle with wt_valid=1 in this order: w[0][0..IN_N-1], ..., w[OUT_N-1][..], then bias[0..OUT_N-1], for IN_N*OUT_N+OUT_N words in total.
REQ-022 After the last word, FILL SHALL go to FDONE, set the internal loaded flag and hold ack_fill=1 until fill=0, then return to IDLE.
REQ-023 If fill drops before the count completes, the block SHALL abort to IDLE and clear loaded.
REQ-024 Words with wt_valid=1 outside FILL SHALL be ignored.
REQ-025 IDLE with req=1, fill=0 and loaded=1 SHALL go to MAC; req with loaded=0 SHALL be ignored.
REQ-026 For neuron j, MAC SHALL initialise acc to bias[j] sign-extended and shifted left by FRAC.
REQ-027 MAC SHALL issue in_trig_r=1 with in_abus_r=i for i=0..IN_N-1 on consecutive cycles.
REQ-028 Each returned in_dbus_r SHALL add w[j][i]*x to acc one cycle after its read, pipelined.
REQ-029 acc SHALL be 2*DW+clog2(IN_N+1)+1 bits signed and SHALL never overflow.
REQ-030 WRITE SHALL compute r = acc arithmetically shifted right by FRAC, saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-031 WRITE SHALL then pass r through the activation (Configuration) and pulse out_trig_w for one cycle with out_abus_w=j.
REQ-032 Each neuron SHALL take exactly IN_N+2 cycles.
REQ-033 After neuron OUT_N-1 the block SHALL go to DONE; ack_network rises OUT_N*(IN_N+2)+1 cycles after the req sample edge.
REQ-034 DONE SHALL hold ack_network=1 until req=0, then return to IDLE; loaded SHALL stay set, so re-evaluation needs no re-fill.
REQ-035 A req drop during MAC or WRITE SHALL NOT abort the evaluation.
REQ-036 in_trig_r and out_trig_w SHALL be 0 in every state other than MAC and WRITE respectively.

Reset
REQ-037 rst=0 SHALL immediately force IDLE, clear loaded and the counters, and drive every output to 0.
REQ-038 Weight storage SHALL NOT be reset; reset in mid-operation discards the operation and requires a new fill.

Configuration
REQ-039 With macro NN_LAYER_RELU_EN defined, the activation SHALL be ReLU (r<0 gives 0); without it, the activation SHALL be identity, writing signed saturated r.

Verification
REQ-040 IN_N=1, OUT_N=1: fill with w=16, b=0; input mem[0]=16; req -> single write of 16 to address 0, ack_network at cycle 4.
REQ-041 Defaults: w=-16 for every weight, b=0, inputs 16,16 -> 0 with NN_LAYER_RELU_EN defined; -32 (0xE0) without it.
REQ-042 IN_N=2: weights 127, inputs 127, b=127 -> writes saturate to 127; all-negative operands with identity activation -> -128.
REQ-043 req with no prior fill -> no in_trig_r and ack_network stays 0; a fill dropped after 3 of 6 words, then req -> also ignored.
REQ-044 rst=0 in the middle of MAC -> outputs 0 asynchronously; after release, req is ignored until a new fill completes.
REQ-045 Simultaneous fill and req in IDLE -> FILL is entered; two back-to-back reqs after one fill -> identical write sequences.
